// File: rtl/seq_shifter_if.sv
// Request/result bundle for seq_shifter: operands and start in, busy/done/result out.
// The master side drives requests; the slave side is the shifter.
interface seq_shifter_if #(
  parameter int unsigned WIDTH = 16
) ();
  localparam int unsigned AW = $clog2(WIDTH);

  logic             i_start;
  logic [1:0]       i_mode;
  logic [AW-1:0]    i_amount;
  logic [WIDTH-1:0] i_in;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_out;

  modport master (
    output i_start, i_mode, i_amount, i_in,
    input  o_busy, o_done, o_out
  );

  modport slave (
    input  i_start, i_mode, i_amount, i_in,
    output o_busy, o_done, o_out
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves up to STEP bits per cycle through SLL/SRL/SRA/(ROL).
// Optional rotate on mode 11 is enabled by defining SEQ_SHIFTER_ROTATE_EN; otherwise mode 11 is SLL.
module seq_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 4
) (
  input  logic          clk,
  input  logic          reset,
  seq_shifter_if.slave  bus
);
  localparam int unsigned AW = $clog2(WIDTH);
  localparam logic [AW:0] StepW  = STEP[AW:0];
  localparam logic [AW:0] WidthW = WIDTH[AW:0];

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_work,  w_work_d;
  logic [AW-1:0]    r_rem,   w_rem_d;
  logic [1:0]       r_mode,  w_mode_d;
  logic [WIDTH-1:0] r_out,   w_out_d;

  logic [AW:0]      w_rem_ext;
  logic [AW:0]      w_k;
  logic [AW-1:0]    w_rem_nxt;
  logic [WIDTH-1:0] w_shl, w_srl, w_sra, w_shifted;

  // Bits moved this cycle: never more than what is left.
  assign w_rem_ext = {1'b0, r_rem};
  assign w_k       = (w_rem_ext > StepW) ? StepW : w_rem_ext;
  assign w_rem_nxt = r_rem - w_k[AW-1:0];

  assign w_shl = r_work << w_k;
  assign w_srl = r_work >> w_k;
  // MSB of the working value stays equal to the original sign bit across steps.
  assign w_sra = $unsigned($signed(r_work) >>> w_k);

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [WIDTH-1:0] w_rol;
  assign w_rol = w_shl | (r_work >> (WidthW - w_k));
`endif

  always_comb begin
    w_shifted = w_shl;
    unique case (r_mode)
      2'b00: w_shifted = w_shl;
      2'b01: w_shifted = w_srl;
      2'b10: w_shifted = w_sra;
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11: w_shifted = w_rol;
`else
      2'b11: w_shifted = w_shl;
`endif
      default: w_shifted = w_shl;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_work_d  = r_work;
    w_rem_d   = r_rem;
    w_mode_d  = r_mode;
    w_out_d   = r_out;
    unique case (r_state)
      StIdle, StDone: begin
        if (bus.i_start) begin
          w_work_d = bus.i_in;
          w_rem_d  = bus.i_amount;
          w_mode_d = bus.i_mode;
          if (bus.i_amount != '0) begin
            w_state_d = StShift;
          end else begin
            w_state_d = StDone;
            w_out_d   = bus.i_in;
          end
        end else begin
          w_state_d = StIdle;
        end
      end
      StShift: begin
        w_work_d = w_shifted;
        w_rem_d  = w_rem_nxt;
        if (w_rem_nxt == '0) begin
          w_state_d = StDone;
          w_out_d   = w_shifted;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_work  <= '0;
      r_rem   <= '0;
      r_mode  <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_d;
      r_work  <= w_work_d;
      r_rem   <= w_rem_d;
      r_mode  <= w_mode_d;
      r_out   <= w_out_d;
    end
  end

  assign bus.o_busy = (r_state == StShift);
  assign bus.o_done = (r_state == StDone);
  assign bus.o_out  = r_out;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=16, STEP=4); expected values are hand-computed.
// Mode-11 expectation follows SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  seq_shifter_if #(.WIDTH(16)) u_if ();

  seq_shifter #(
    .WIDTH(16),
    .STEP (4)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; returns latency, busy cycles, result.
  task automatic run_op(input logic [15:0] din, input logic [1:0] mode, input logic [3:0] amt,
                        output int lat, output int busy_cyc, output logic [15:0] res);
    u_if.i_in     = din;
    u_if.i_mode   = mode;
    u_if.i_amount = amt;
    u_if.i_start  = 1'b1;
    tick();
    u_if.i_start  = 1'b0;
    lat      = 1;
    busy_cyc = 0;
    while (!u_if.o_done && lat < 40) begin
      if (u_if.o_busy) busy_cyc++;
      tick();
      lat++;
    end
    res = u_if.o_out;
  endtask

  int          lat;
  int          bcyc;
  logic [15:0] res;
  logic [15:0] rol_exp;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    u_if.i_start  = 1'b0;
    u_if.i_mode   = 2'b00;
    u_if.i_amount = '0;
    u_if.i_in     = '0;
    tick();
    tick();
    check("rst_busy", {31'b0, u_if.o_busy}, 32'd0);
    check("rst_done", {31'b0, u_if.o_done}, 32'd0);
    check("rst_out", {16'b0, u_if.o_out}, 32'h0);
    reset = 1'b0;
    tick();

    // SLL by one full step
    run_op(16'h3FFF, 2'b00, 4'd4, lat, bcyc, res);
    check("sll4_lat", lat, 2);
    check("sll4_busy", bcyc, 1);
    check("sll4_out", {16'b0, res}, 32'hFFF0);
    tick();
    check("sll4_done_pulse", {31'b0, u_if.o_done}, 32'd0);
    check("sll4_out_hold", {16'b0, u_if.o_out}, 32'hFFF0);

    // Back-to-back: second start issued in the DONE cycle
    run_op(16'h0001, 2'b00, 4'd4, lat, bcyc, res);
    check("b2b1_lat", lat, 2);
    check("b2b1_out", {16'b0, res}, 32'h0010);
    run_op(16'h8000, 2'b10, 4'd15, lat, bcyc, res);
    check("b2b2_lat", lat, 5);
    check("b2b2_busy", bcyc, 4);
    check("b2b2_out", {16'b0, res}, 32'hFFFF);
    tick();

    // Zero shift goes straight to DONE
    run_op(16'hA5A5, 2'b01, 4'd0, lat, bcyc, res);
    check("srl0_lat", lat, 1);
    check("srl0_busy", bcyc, 0);
    check("srl0_out", {16'b0, res}, 32'hA5A5);
    tick();

    // Start during SHIFT must be ignored
    u_if.i_in     = 16'h00F0;
    u_if.i_mode   = 2'b01;
    u_if.i_amount = 4'd9;
    u_if.i_start  = 1'b1;
    tick();
    u_if.i_start  = 1'b0;
    check("ign_busy_c1", {31'b0, u_if.o_busy}, 32'd1);
    u_if.i_in     = 16'hFFFF;
    u_if.i_mode   = 2'b00;
    u_if.i_amount = 4'd1;
    u_if.i_start  = 1'b1;
    tick();
    u_if.i_start  = 1'b0;
    check("ign_busy_c2", {31'b0, u_if.o_busy}, 32'd1);
    check("ign_out_partial", {16'b0, u_if.o_out}, 32'hA5A5);
    tick();
    check("ign_done_c3", {31'b0, u_if.o_done}, 32'd0);
    tick();
    check("ign_done_c4", {31'b0, u_if.o_done}, 32'd1);
    check("ign_out", {16'b0, u_if.o_out}, 32'h0000);
    tick();
    check("ign_idle_busy", {31'b0, u_if.o_busy}, 32'd0);

    // Mode 11: rotate when enabled, plain SLL otherwise
`ifdef SEQ_SHIFTER_ROTATE_EN
    rol_exp = 16'h0018;
`else
    rol_exp = 16'h0010;
`endif
    run_op(16'h8001, 2'b11, 4'd4, lat, bcyc, res);
    check("m11_lat", lat, 2);
    check("m11_out", {16'b0, res}, {16'b0, rol_exp});
    tick();

    // Extra patterns: SRA of a positive value, SRL with partial last step
    run_op(16'h7000, 2'b10, 4'd3, lat, bcyc, res);
    check("sra3_lat", lat, 2);
    check("sra3_out", {16'b0, res}, 32'h0E00);
    run_op(16'h00FF, 2'b01, 4'd5, lat, bcyc, res);
    check("srl5_lat", lat, 3);
    check("srl5_out", {16'b0, res}, 32'h0007);
    tick();

    // Reset during the second SHIFT cycle aborts without done
    u_if.i_in     = 16'h1234;
    u_if.i_mode   = 2'b00;
    u_if.i_amount = 4'd12;
    u_if.i_start  = 1'b1;
    tick();
    u_if.i_start  = 1'b0;
    tick();
    check("abort_busy_c2", {31'b0, u_if.o_busy}, 32'd1);
    reset        = 1'b1;
    u_if.i_start = 1'b1;
    tick();
    reset        = 1'b0;
    u_if.i_start = 1'b0;
    check("abort_busy", {31'b0, u_if.o_busy}, 32'd0);
    check("abort_done", {31'b0, u_if.o_done}, 32'd0);
    check("abort_out", {16'b0, u_if.o_out}, 32'h0);
    // Fresh start in the first cycle after reset release
    run_op(16'h1234, 2'b00, 4'd12, lat, bcyc, res);
    check("post_rst_lat", lat, 4);
    check("post_rst_busy", bcyc, 3);
    check("post_rst_out", {16'b0, res}, 32'h4000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter STEP, default 4, maximum bits shifted per cycle; legal range 1..WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-006 mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see REQ-022).
REQ-007 amount  input  log2(WIDTH)  shift distance, 0..WIDTH-1.
REQ-008 in  input  WIDTH  operand.
REQ-009 busy  output  1  high while in SHIFT.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 out  output  WIDTH  result; holds its value until the next accepted start.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture in, mode and amount into internal registers; the next state SHALL be SHIFT if amount>0, else DONE.
REQ-014 In IDLE or DONE, start=0 SHALL give next state IDLE.
REQ-015 Each SHIFT cycle SHALL shift the working register by k=min(STEP, remaining) and decrement remaining by k; when remaining reaches 0, the next state SHALL be DONE.
REQ-016 Latency SHALL be exact: with N=ceil(amount/STEP), done is high in the cycle beginning N+1 rising edges after the edge that accepted start; N=0 gives 1 cycle.
REQ-017 SLL and SRL SHALL zero-fill; SRA SHALL replicate the original in[WIDTH-1] on every step.
REQ-018 out SHALL update only on entry to DONE, never with partial results.
REQ-019 busy SHALL be 1 exactly while in SHIFT; done SHALL be 1 exactly while in DONE.
REQ-020 start asserted during SHIFT SHALL be ignored, with no effect on the operation in flight or on captured operands.
REQ-021 start asserted in DONE SHALL be accepted, giving back-to-back operation with no idle cycle.

Configuration
REQ-022 With macro SEQ_SHIFTER_ROTATE_EN defined, mode 11 SHALL rotate left by amount; when it is undefined, mode 11 SHALL behave exactly as SLL, and no rotate logic SHALL be synthesised.

Reset
REQ-023 reset=1 at a rising edge SHALL force the state to IDLE, busy=0, done=0 and out=0, with remaining and the working register cleared.
REQ-024 Reset SHALL take priority over start and SHALL abort any operation in flight without producing a done pulse.
REQ-025 In the first cycle after reset is released, start SHALL be accepted normally.

Verification (WIDTH=16, STEP=4)
REQ-026 Bench SHALL drive in=16'h3FFF, mode=SLL, amount=4 -> done 2 cycles after start, out=16'hFFF0.
REQ-027 Bench SHALL drive in=16'h0001, SLL, amount=4, then in=16'h8000, SRA, amount=15 back-to-back from DONE -> first out=16'h0010; second done 5 cycles later, out=16'hFFFF, busy high 4 cycles.
REQ-028 Bench SHALL drive in=16'hA5A5, SRL, amount=0 -> done 1 cycle after start, busy never high, out=16'hA5A5.
REQ-029 Bench SHALL drive in=16'h00F0, SRL, amount=9, and pulse start with in=16'hFFFF during SHIFT -> second start ignored, done after 4 cycles, out=16'h0000.
REQ-030 Bench SHALL drive in=16'h8001, mode=11, amount=4 -> out=16'h0018 with SEQ_SHIFTER_ROTATE_EN defined, out=16'h0010 without.
REQ-031 Bench SHALL assert reset during the second SHIFT cycle of SLL amount=12 -> next cycle in IDLE with out=0, no done pulse, and a fresh start then completes correctly.
